// File: rtl/tdm_demux_if.sv
// Bus between a TDM sample source and the tdm_demux receiver.
// The source drives din/din_valid/frame_start; the demux drives the rebuilt frame and status.
interface tdm_demux_if #(
  parameter int WIDTH = 1,
  parameter int LANES = 4
);
  localparam int SEL_W = $clog2(LANES);

  logic [WIDTH-1:0]       din;
  logic                   din_valid;
  logic                   frame_start;
  logic [LANES*WIDTH-1:0] out;
  logic                   out_valid;
  logic [SEL_W-1:0]       select;
  logic                   busy;
  logic                   frame_err;

  // Accept rule: a sample is taken on any rising edge with din_valid=1.
  // There is no back-pressure. out_valid and frame_err are single-cycle pulses.
  modport master (
    output din, din_valid, frame_start,
    input  out, out_valid, select, busy, frame_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output out, out_valid, select, busy, frame_err
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: collects LANES serialized samples per frame into a parallel word.
// Slot k of a frame lands at out[k*WIDTH +: WIDTH]. An early frame_start aborts and restarts the frame.
module tdm_demux #(
  parameter int WIDTH = 1,
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux_if.slave   bus
);
  localparam int SEL_W = $clog2(LANES);
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

  typedef enum logic [0:0] {IDLE, COLLECT} state_t;

  state_t                       state_q, state_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic [LANES-2:0][WIDTH-1:0]  shadow_q, shadow_d;
  logic [LANES*WIDTH-1:0]       out_q, out_d;
  logic                         out_valid_q, out_valid_d;
  logic                         err_q, err_d;
  logic                         busy_q, busy_d;
  logic [1:0]                   rst_sync;
  logic                         rst_int_n;

  // Reset asserts immediately and releases two clock edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        IDLE: begin
          // Samples outside a frame are dropped until a frame_start arrives.
          if (bus.frame_start) begin
            shadow_d[0] = bus.din;
            sel_d       = SEL_W'(1);
            state_d     = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.frame_start) begin
            // A restart wins even on the last slot position: partial frame is dropped.
            err_d       = 1'b1;
            shadow_d[0] = bus.din;
            sel_d       = SEL_W'(1);
          end else if (sel_q == LAST_SLOT) begin
            out_d       = {bus.din, shadow_q};
            out_valid_d = 1'b1;
            sel_d       = '0;
            state_d     = IDLE;
          end else begin
            for (int i = 0; i < LANES - 1; i++) begin
              if (sel_q == SEL_W'(i)) shadow_d[i] = bus.din;
            end
            sel_d = sel_q + SEL_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == COLLECT);
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.select    = sel_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = err_q;
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of our 4:1 mux lane-select scheme.
- Accepts one serialized sample per valid cycle. Slot k of a frame corresponds to mux select=k.
- Reassembles each frame into a parallel LANES-wide word and publishes it with a one-cycle valid pulse.
- Sits after a mux-based serializer and rebuilds the original parallel input vector.

Parameters:
- WIDTH, 1, bit width of one sample/lane
- LANES, 4, slots per frame; power of two, >=2; slot index width SEL_W = log2(LANES) derived internally

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  serialized sample
- din_valid  input  1  din carries a sample this cycle
- frame_start  input  1  qualified by din_valid; marks din as slot 0
- out  output  LANES*WIDTH  reassembled frame; slot k at out[k*WIDTH +: WIDTH]
- out_valid  output  1  one-cycle pulse; out holds a new complete frame
- select  output  SEL_W  slot index the next accepted sample will fill
- busy  output  1  high while in COLLECT
- frame_err  output  1  one-cycle pulse; frame aborted by an early frame_start

Behaviour:
- Reset: asynchronous assert, synchronous release.
  - State IDLE; out=0, out_valid=0, select=0, busy=0, frame_err=0; shadow register cleared.
- Accept: a sample is accepted on a rising edge with din_valid=1. din_valid=0 means no state change and the slot counter holds, so gaps are allowed anywhere.
- IDLE:
  - Accepted sample with frame_start=0 is dropped; no outputs change.
  - Accepted sample with frame_start=1 is stored to shadow slot 0; select<=1; go to COLLECT.
- COLLECT:
  - Accepted sample with frame_start=0 is stored to shadow slot[select]; select increments.
  - When select==LANES-1, that sample completes the frame:
    - out <= {din, shadow slots LANES-2..0}
    - out_valid <= 1 for exactly one cycle
    - select <= 0
    - go to IDLE
- Latency: out and out_valid are visible in the cycle after the edge that accepts the last slot. out holds its value until the next completed frame.
- Early frame_start in COLLECT (accepted sample with frame_start=1):
  - frame_err pulses one cycle.
  - Partial frame discarded; out and out_valid unaffected.
  - Current din stored as slot 0; select<=1; remain in COLLECT.
- Back-to-back: a frame_start sample in the cycle immediately after completion starts the next frame with no bubble. out_valid and the new slot-0 capture occur together.
- frame_start with din_valid=0 is ignored in all states.
- LANES=... boundary: a frame_start sample on the final slot position in COLLECT counts as an early frame_start (error plus restart), not as completion.
- Reset mid-frame: partial data is lost, out is cleared, and no out_valid is generated.
- busy = (state==COLLECT), registered.

Test Plan:
- Reset, then (WIDTH=1, LANES=4) din 1,0,1,1 on four consecutive valid cycles, frame_start on the first -> one cycle after the 4th edge, out=4'b1101 and out_valid high for 1 cycle; select sequence 1,2,3,0.
- Same frame with din_valid=0 for 3 cycles between slots 1 and 2 -> identical out=4'b1101; select holds at 2 during the gap; single out_valid pulse.
- din 1,1 (frame_start on the first), then frame_start with din 0, then 0,1,0 -> frame_err pulses once on the third sample; out=4'b0100 after completion; no out_valid for the aborted frame.
- Valid samples 1,1,1 without frame_start while IDLE -> out stays 0, out_valid stays 0, select stays 0, busy stays 0.
- Two back-to-back frames 1,0,0,0 then 0,1,1,1 -> out_valid pulses on two cycles exactly 4 cycles apart; out=4'b0001 then 4'b1110.
- rst_n asserted asynchronously after 2 slots of a frame with previous out=4'b1101 -> out=0, busy=0 immediately; a following clean frame 0,0,1,0 yields out=4'b0100.
